game_turn_scheduler: RTL and testbench
======================================

# game_turn_scheduler

Turn sequencer for the two-player dice race, sitting between the dice-recognition path and the UI game renderer. It accepts validated dice rolls, advances the active player's tile, and converts the tile to an x target. It issues the renderer's `pos_valid` pulse and waits for the renderer's `turn_done`. It then applies bonus-tile and goal rules, alternates turns, and raises `winner_valid`.

## Interface
Parameters:
- `TILE_X0`, 20: pixel x of tile 0.
- `TILE_PITCH`, 60: pixel spacing between tiles.
- `GOAL_TILE`, 9: finishing tile index.
- `TIMEOUT_CYCLES`, 50_000_000: maximum wait for `turn_done` before proceeding anyway.

Ports:
- `clk` in 1: system/pixel clock.
- `rst` in 1: asynchronous, active-high reset.
- `dice_valid` in 1: one-cycle pulse; `dice_value` is valid.
- `dice_value` in 3: roll result; legal values are 1..6.
- `restart` in 1: one-cycle pulse requesting a new game.
- `turn_done` in 1: one-cycle pulse from the renderer when the move animation finishes.
- `dice_ready` out 1: high while waiting for a roll.
- `pos_valid` out 1: one-cycle pulse to the renderer.
- `player1_pos_x` out 10: renderer target x for player 1.
- `player2_pos_x` out 10: renderer target x for player 2.
- `active_player` out 1: 0 = player 1, 1 = player 2.
- `winner_valid` out 1: game over.
- `winner_id` out 1: winning player; meaningful only when `winner_valid` is high.
- `render_reset` out 1: one-cycle pulse; the top level ORs it into the renderer `rst`.

## Operation
- States: `WAIT_DICE`, `ISSUE`, `WAIT_DONE`, `CHECK`, `FINISH`.
- Reset values:
  - State is `WAIT_DICE`.
  - Both tiles are 0, so both `pos_x` outputs equal `TILE_X0`.
  - `active_player` = 0; `bonus_used` = 0.
  - `pos_valid`, `winner_valid`, `winner_id` and `render_reset` are 0.
- `WAIT_DICE`:
  - `dice_ready` = 1.
  - `dice_valid` with a value of 1..6: the active tile becomes min(tile + value, `GOAL_TILE`), then go to `ISSUE`.
  - Values 0 and 7 are ignored; the state does not change.
  - `dice_valid` is ignored in every other state.
- `ISSUE`: `pos_valid` = 1 for exactly this cycle; the timeout counter clears; go to `WAIT_DONE`.
- `WAIT_DONE`: the counter increments each cycle. Go to `CHECK` on `turn_done` or when the counter reaches `TIMEOUT_CYCLES`-1, whichever comes first.
- `CHECK` (one cycle):
  - If tile == `GOAL_TILE`: go to `FINISH`, with `winner_id` = `active_player`.
  - Else if the tile is even, nonzero, and `bonus_used` = 0 (bonus tiles 2/4/6/8): set `bonus_used`, keep `active_player`, go to `WAIT_DICE`.
  - Else: toggle `active_player`, clear `bonus_used`, go to `WAIT_DICE`.
- `FINISH`: `winner_valid` = 1 and stays held until `restart` or `rst`.
- `restart`, honoured in any state:
  - Tiles, `active_player`, `bonus_used`, `winner_valid` and the counter are cleared.
  - `render_reset` pulses for 1 cycle.
  - The state becomes `WAIT_DICE`.
  - `restart` has priority over every same-cycle event.
- Arithmetic:
  - Tiles are 4-bit; the sum uses a 5-bit intermediate before saturation.
  - pos_x = `TILE_X0` + `TILE_PITCH`*tile, computed in 10 bits. Parameters must keep `TILE_X0` + `TILE_PITCH`*`GOAL_TILE` < 640; this is checked by an elaboration assertion.
- Only the active player's tile and pos_x change in a turn.

## Timing
- All outputs are registered.
- A roll accepted at edge T produces the updated pos_x and `pos_valid` = 1 in cycle T+1; pos_x is stable before and throughout the pulse.
- `turn_done` sampled at edge T' gives `CHECK` in cycle T'+1. After that edge, the updated `active_player` or `winner_valid` is visible and `dice_ready` is high from cycle T'+2 onward.
- A `turn_done` arriving in the same cycle as a timeout counts once.
- A `turn_done` outside `WAIT_DONE` is ignored.
- The counter width is $clog2(`TIMEOUT_CYCLES`).
- Asynchronous `rst` mid-turn aborts immediately to the reset values; no `pos_valid` is emitted afterwards.

## Structure
- `game_pkg` holds:
  - the `turn_state_t` enum;
  - `GOAL_TILE`, `TILE_X0` and `TILE_PITCH` defaults;
  - a `tile_to_x` function shared with any future tile-marker renderer.
- One sub-module, `turn_timeout_counter`: clear/enable/expire, parameterised by `TIMEOUT_CYCLES`.
- Everything else lives in a single always_ff FSM with a combinational next-state block.

## Test plan
- Roll P1 = 3 -> `pos_valid` pulses once, `player1_pos_x` = 200, `player2_pos_x` = 20. After `turn_done`, `active_player` = 1.
- P1 rolls 2, reaching tile 2 -> `active_player` stays 0 and `dice_ready` returns. P1 then rolls 2, reaching tile 4 -> `active_player` toggles to 1 (bonus already used).
- P1 at tile 7 rolls 6 -> tile saturates to 9, pos_x = 560. After `turn_done`: `winner_valid` = 1, `winner_id` = 0, and further `dice_valid` produces no `pos_valid`.
- Dice value 0 or 7, or `dice_valid` during `WAIT_DONE` -> no state change, no `pos_valid`.
- With `TIMEOUT_CYCLES` = 16 and `turn_done` withheld -> `CHECK` occurs exactly 16 cycles after `ISSUE` and the turn passes.
- `restart` during `FINISH`, and also in the same cycle as `turn_done` -> `render_reset` pulses once, both pos_x = 20, `winner_valid` = 0, `active_player` = 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and defaults for the dice-race turn sequencer.
//   turn_state_t : turn sequencer states
//   DEFAULT_*    : board geometry defaults (tile 0 x, tile pitch, goal tile)
//   tile_to_x    : tile index -> renderer x, reusable by tile-marker renderers
package game_pkg;

  typedef enum logic [2:0] {
    WAIT_DICE = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    CHECK     = 3'd3,
    FINISH    = 3'd4
  } turn_state_t;

  localparam int unsigned DEFAULT_TILE_X0    = 20;
  localparam int unsigned DEFAULT_TILE_PITCH = 60;
  localparam int unsigned DEFAULT_GOAL_TILE  = 9;

  // Result is truncated to the 10-bit screen coordinate; the top level
  // guarantees at elaboration that the goal tile stays on screen.
  function automatic logic [9:0] tile_to_x(input logic [3:0]  tile,
                                           input int unsigned x0,
                                           input int unsigned pitch);
    int unsigned x;
    x = x0 + pitch * 32'(tile);
    return x[9:0];
  endfunction

endpackage

// File: rtl/turn_timeout_counter.sv
// Bounded wait for the renderer's turn_done.
//   clk, rst : clock, async active-high reset
//   clr      : zero the count (has priority over en)
//   en       : count this cycle
//   expire   : high in the cycle whose increment brings the count to
//              TIMEOUT_CYCLES-1, so the caller can leave on that edge
module turn_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  assign expire = en && !clr && ((32'(cnt_q) + 32'd1) == (TIMEOUT_CYCLES - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_turn_scheduler.sv
// Two-player dice-race turn sequencer between dice recognition and renderer.
//   dice_valid/dice_value : validated roll (1..6 accepted)
//   restart               : new game, overrides everything that cycle
//   turn_done             : renderer finished the move animation
//   dice_ready            : waiting for a roll
//   pos_valid             : one-cycle "new target" pulse to the renderer
//   player1/2_pos_x       : renderer x targets
//   active_player         : 0 = player 1, 1 = player 2
//   winner_valid/id       : game over and who won
//   render_reset          : one-cycle pulse ORed into the renderer reset
//
// state     | meaning
// WAIT_DICE | idle, accepting a roll for active_player
// ISSUE     | new target registered, pos_valid high
// WAIT_DONE | waiting for turn_done or timeout
// CHECK     | apply goal / bonus / turn-pass rules
// FINISH    | winner held until restart or rst
module game_turn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned TILE_X0        = DEFAULT_TILE_X0,
  parameter int unsigned TILE_PITCH     = DEFAULT_TILE_PITCH,
  parameter int unsigned GOAL_TILE      = DEFAULT_GOAL_TILE,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dice_valid,
  input  logic [2:0] dice_value,
  input  logic       restart,
  input  logic       turn_done,
  output logic       dice_ready,
  output logic       pos_valid,
  output logic [9:0] player1_pos_x,
  output logic [9:0] player2_pos_x,
  output logic       active_player,
  output logic       winner_valid,
  output logic       winner_id,
  output logic       render_reset
);

  if ((TILE_X0 + TILE_PITCH * GOAL_TILE) >= 640 || GOAL_TILE > 15) begin : g_bad_geometry
    $error("game_turn_scheduler: goal tile off screen or beyond 4-bit tile range");
  end

  localparam logic [3:0] GOAL = 4'(GOAL_TILE);

  turn_state_t state_q, state_d;
  logic [3:0]  tile1_q, tile1_d, tile2_q, tile2_d;
  logic        active_q, active_d, bonus_q, bonus_d;
  logic        win_id_q, win_id_d;
  logic [9:0]  pos1_q, pos1_d, pos2_q, pos2_d;
  logic        pos_valid_q, dice_ready_q, winner_valid_q, render_reset_q;
  logic [3:0]  cur_tile;
  logic [4:0]  sum5;
  logic        tmo_expire;

  turn_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (restart || (state_q == ISSUE)),
    .en     (state_q == WAIT_DONE),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d  = state_q;
    tile1_d  = tile1_q;
    tile2_d  = tile2_q;
    active_d = active_q;
    bonus_d  = bonus_q;
    win_id_d = win_id_q;
    cur_tile = active_q ? tile2_q : tile1_q;
    sum5     = {1'b0, cur_tile} + {2'b00, dice_value};

    case (state_q)
      WAIT_DICE: begin
        if (dice_valid && dice_value != 3'd0 && dice_value != 3'd7) begin
          if (sum5 >= {1'b0, GOAL}) begin
            if (active_q) tile2_d = GOAL;
            else          tile1_d = GOAL;
          end else begin
            if (active_q) tile2_d = sum5[3:0];
            else          tile1_d = sum5[3:0];
          end
          state_d = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (turn_done || tmo_expire) state_d = CHECK;
      CHECK: begin
        if (cur_tile == GOAL) begin
          win_id_d = active_q;
          state_d  = FINISH;
        end else if (!cur_tile[0] && cur_tile != 4'd0 && !bonus_q) begin
          bonus_d = 1'b1;
          state_d = WAIT_DICE;
        end else begin
          active_d = ~active_q;
          bonus_d  = 1'b0;
          state_d  = WAIT_DICE;
        end
      end
      FINISH:  state_d = FINISH;
      default: state_d = WAIT_DICE;
    endcase

    if (restart) begin
      state_d  = WAIT_DICE;
      tile1_d  = 4'd0;
      tile2_d  = 4'd0;
      active_d = 1'b0;
      bonus_d  = 1'b0;
      win_id_d = 1'b0;
    end

    // Targets are registered with the tile so pos_x is valid with pos_valid.
    pos1_d = tile_to_x(tile1_d, TILE_X0, TILE_PITCH);
    pos2_d = tile_to_x(tile2_d, TILE_X0, TILE_PITCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= WAIT_DICE;
      tile1_q        <= 4'd0;
      tile2_q        <= 4'd0;
      active_q       <= 1'b0;
      bonus_q        <= 1'b0;
      win_id_q       <= 1'b0;
      pos1_q         <= tile_to_x(4'd0, TILE_X0, TILE_PITCH);
      pos2_q         <= tile_to_x(4'd0, TILE_X0, TILE_PITCH);
      pos_valid_q    <= 1'b0;
      dice_ready_q   <= 1'b1;
      winner_valid_q <= 1'b0;
      render_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tile1_q        <= tile1_d;
      tile2_q        <= tile2_d;
      active_q       <= active_d;
      bonus_q        <= bonus_d;
      win_id_q       <= win_id_d;
      pos1_q         <= pos1_d;
      pos2_q         <= pos2_d;
      pos_valid_q    <= (state_d == ISSUE);
      dice_ready_q   <= (state_d == WAIT_DICE);
      winner_valid_q <= (state_d == FINISH);
      render_reset_q <= restart;
    end
  end

  assign dice_ready    = dice_ready_q;
  assign pos_valid     = pos_valid_q;
  assign player1_pos_x = pos1_q;
  assign player2_pos_x = pos2_q;
  assign active_player = active_q;
  assign winner_valid  = winner_valid_q;
  assign winner_id     = win_id_q;
  assign render_reset  = render_reset_q;

endmodule

// File: tb/tb_game_turn_scheduler.sv
module tb_game_turn_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dice_valid = 1'b0;
  logic [2:0] dice_value = 3'd0;
  logic       restart = 1'b0;
  logic       turn_done = 1'b0;
  logic       dice_ready, pos_valid, active_player, winner_valid, winner_id, render_reset;
  logic [9:0] player1_pos_x, player2_pos_x;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  game_turn_scheduler #(
    .TILE_X0(20), .TILE_PITCH(60), .GOAL_TILE(9), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .dice_valid(dice_valid), .dice_value(dice_value),
    .restart(restart), .turn_done(turn_done), .dice_ready(dice_ready),
    .pos_valid(pos_valid), .player1_pos_x(player1_pos_x), .player2_pos_x(player2_pos_x),
    .active_player(active_player), .winner_valid(winner_valid), .winner_id(winner_id),
    .render_reset(render_reset)
  );

  typedef struct {
    logic       rs, dv;
    logic [2:0] val;
    logic       td;
    logic       pv, dr;
    logic [9:0] p1, p2;
    logic       ap, wv, wid, rr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rs, input int dv, input int val, input int td,
                              input int pv, input int dr, input int p1, input int p2,
                              input int ap, input int wv, input int wid, input int rr);
    vec_t v;
    v.rs = 1'(rs); v.dv = 1'(dv); v.val = 3'(val); v.td = 1'(td);
    v.pv = 1'(pv); v.dr = 1'(dr); v.p1 = 10'(p1); v.p2 = 10'(p2);
    v.ap = 1'(ap); v.wv = 1'(wv); v.wid = 1'(wid); v.rr = 1'(rr);
    return v;
  endfunction

  task automatic check_outputs(input string tag, input vec_t v);
    nvec++;
    if (pos_valid !== v.pv || dice_ready !== v.dr || player1_pos_x !== v.p1 ||
        player2_pos_x !== v.p2 || active_player !== v.ap || winner_valid !== v.wv ||
        winner_id !== v.wid || render_reset !== v.rr) begin
      nerr++;
      $display("FAIL %s: got pv=%0d dr=%0d p1=%0d p2=%0d ap=%0d wv=%0d wid=%0d rr=%0d, want pv=%0d dr=%0d p1=%0d p2=%0d ap=%0d wv=%0d wid=%0d rr=%0d",
               tag, pos_valid, dice_ready, player1_pos_x, player2_pos_x, active_player,
               winner_valid, winner_id, render_reset,
               v.pv, v.dr, v.p1, v.p2, v.ap, v.wv, v.wid, v.rr);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then check outputs.
  task automatic apply(input string tag, input vec_t v);
    restart = v.rs; dice_valid = v.dv; dice_value = v.val; turn_done = v.td;
    @(posedge clk); #1;
    restart = 1'b0; dice_valid = 1'b0; dice_value = 3'd0; turn_done = 1'b0;
    check_outputs(tag, v);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int pv_seen;
    //               rs dv v td | pv dr  p1   p2 ap wv wid rr
    vecs.push_back(mk(0,1,3,0,  1,0,200, 20,0,0,0,0)); // P1 rolls 3
    vecs.push_back(mk(0,0,0,0,  0,0,200, 20,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,0,200, 20,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,  0,0,200, 20,0,0,0,0)); // -> CHECK
    vecs.push_back(mk(0,0,0,0,  0,1,200, 20,1,0,0,0)); // turn passes
    vecs.push_back(mk(0,1,0,0,  0,1,200, 20,1,0,0,0)); // value 0 ignored
    vecs.push_back(mk(0,1,7,0,  0,1,200, 20,1,0,0,0)); // value 7 ignored
    vecs.push_back(mk(0,1,2,0,  1,0,200,140,1,0,0,0)); // P2 to tile 2
    vecs.push_back(mk(0,1,5,0,  0,0,200,140,1,0,0,0)); // roll in ISSUE ignored
    vecs.push_back(mk(0,0,0,1,  0,0,200,140,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,1,200,140,1,0,0,0)); // bonus: P2 again
    vecs.push_back(mk(0,1,2,0,  1,0,200,260,1,0,0,0)); // P2 to tile 4
    vecs.push_back(mk(0,0,0,0,  0,0,200,260,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,  0,0,200,260,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,1,200,260,0,0,0,0)); // bonus used: toggle
    vecs.push_back(mk(0,1,4,0,  1,0,440,260,0,0,0,0)); // P1 to tile 7
    vecs.push_back(mk(0,0,0,1,  0,0,440,260,0,0,0,0)); // turn_done in ISSUE ignored
    vecs.push_back(mk(0,1,1,0,  0,0,440,260,0,0,0,0)); // roll in WAIT_DONE ignored
    vecs.push_back(mk(0,0,0,1,  0,0,440,260,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,1,440,260,1,0,0,0));
    vecs.push_back(mk(0,1,1,0,  1,0,440,320,1,0,0,0)); // P2 to tile 5
    vecs.push_back(mk(0,0,0,0,  0,0,440,320,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,  0,0,440,320,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,1,440,320,0,0,0,0));
    vecs.push_back(mk(0,1,6,0,  1,0,560,320,0,0,0,0)); // 7+6 saturates at 9
    vecs.push_back(mk(0,0,0,0,  0,0,560,320,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,  0,0,560,320,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,0,560,320,0,1,0,0)); // P1 wins
    vecs.push_back(mk(0,1,3,0,  0,0,560,320,0,1,0,0)); // roll after win ignored
    vecs.push_back(mk(0,0,0,1,  0,0,560,320,0,1,0,0));
    vecs.push_back(mk(1,0,0,0,  0,1, 20, 20,0,0,0,1)); // restart in FINISH
    vecs.push_back(mk(0,0,0,0,  0,1, 20, 20,0,0,0,0));
    vecs.push_back(mk(0,1,5,0,  1,0,320, 20,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,0,320, 20,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,  0,1, 20, 20,0,0,0,1)); // restart beats turn_done
    vecs.push_back(mk(0,0,0,0,  0,1, 20, 20,0,0,0,0));
    vecs.push_back(mk(1,1,3,0,  0,1, 20, 20,0,0,0,1)); // restart beats roll

    #23 rst = 1'b0;
    #1;
    check_outputs("reset_values", mk(0,0,0,0, 0,1,20,20,0,0,0,0));
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Timeout: roll 1 for P1, withhold turn_done; dice_ready returns 17
    // samples after ISSUE (CHECK sits 16 cycles after ISSUE).
    apply("tmo_issue", mk(0,1,1,0, 1,0,80,20,0,0,0,0));
    n = 0;
    while (!dice_ready && n < 40) begin
      idle_cycle();
      n++;
    end
    nvec++;
    if (n != 17) begin
      nerr++;
      $display("FAIL timeout_latency: dice_ready back after %0d cycles, want 17", n);
    end
    check_outputs("timeout_pass", mk(0,0,0,0, 0,1,80,20,1,0,0,0));

    // Async reset mid-turn: P2 rolls 2, rst mid-cycle during ISSUE.
    apply("rst_issue", mk(0,1,2,0, 1,0,80,140,1,0,0,0));
    #2 rst = 1'b1;
    #1;
    check_outputs("async_rst", mk(0,0,0,0, 0,1,20,20,0,0,0,0));
    @(negedge clk);
    rst = 1'b0;
    pv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      idle_cycle();
      if (pos_valid) pv_seen++;
    end
    nvec++;
    if (pv_seen != 0) begin
      nerr++;
      $display("FAIL no_pv_after_rst: pos_valid seen %0d times, want 0", pv_seen);
    end
    check_outputs("after_rst", mk(0,0,0,0, 0,1,20,20,0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
